// File: rtl/uart_program_loader.sv
// Boot loader: receives a 4-byte little-endian length and that many program bytes over
// the UART, packs them into 32-bit words in instruction memory, then ACKs and releases the CPU.
module uart_program_loader #(
  parameter int              ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              MAX_BYTES = 65536,
  parameter logic [7:0]      ACK_BYTE  = 8'hAA
) (
  input  logic              i_sys_clock,
  input  logic              i_reset,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic              i_tx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_run,
  output logic              o_busy,
  output logic              o_load_err
);

  localparam int REM_W = $clog2(MAX_BYTES + 1);
  localparam logic [REM_W-1:0]  REM_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [31:0]       MAX_LEN  = 32'(MAX_BYTES);

  // S_CHECK is the cycle after the 4th length byte, where the registered count is judged.
  localparam logic [2:0] S_LEN   = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]        r_state;
  logic [31:0]       r_len;
  logic [1:0]        r_len_cnt;
  logic [REM_W-1:0]  r_rem;
  logic [1:0]        r_lane;
  logic [31:0]       r_buf;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic              r_live;
  logic [31:0]       w_word;
  logic              w_word_done;

  // Fill buffer with the incoming byte merged in; lanes above it are still zero.
  always_comb begin
    w_word = r_buf;
    w_word[{r_lane, 3'b000} +: 8] = i_rx_data;
  end

  assign w_word_done = (r_lane == 2'd3) || (r_rem == REM_ONE);

  always_ff @(posedge i_sys_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_LEN;
      r_len     <= '0;
      r_len_cnt <= '0;
      r_rem     <= '0;
      r_lane    <= '0;
      r_buf     <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_addr    <= BASE_ADDR;
      r_live    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_we   <= 1'b0;
      if (r_we) begin
        r_addr <= r_addr + ADDR_ONE;
      end
      case (r_state)
        S_LEN: begin
          if (i_rx_valid) begin
            r_len     <= {i_rx_data, r_len[31:8]};
            r_len_cnt <= r_len_cnt + 2'd1;
            if (r_len_cnt == 2'd3) begin
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (r_len == 32'd0) begin
            r_state <= S_ACK;
          end else if (r_len > MAX_LEN) begin
            r_state <= S_ERR;
          end else begin
            r_state <= S_DATA;
            r_rem   <= r_len[REM_W-1:0];
            r_lane  <= '0;
            r_buf   <= '0;
          end
        end
        S_DATA: begin
          if (i_rx_valid) begin
            r_rem  <= r_rem - REM_ONE;
            r_lane <= r_lane + 2'd1;
            if (w_word_done) begin
              r_wdata <= w_word;
              r_we    <= 1'b1;
              r_buf   <= '0;
            end else begin
              r_buf <= w_word;
            end
            if (r_rem == REM_ONE) begin
              r_state <= S_FLUSH;
            end
          end
        end
        // The final word's write strobe is high during this single cycle.
        S_FLUSH: r_state <= S_ACK;
        S_ACK: begin
          if (i_tx_ready) begin
            r_state <= S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_valid   = (r_state == S_ACK);
  assign o_tx_data    = o_tx_valid ? ACK_BYTE : 8'h00;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_cpu_run    = (r_state == S_RUN);
  assign o_load_err   = (r_state == S_ERR);
  // r_live keeps busy low while reset is held even though the state is LEN.
  assign o_busy       = r_live && (r_state <= S_ACK);

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed-plus-random bench for uart_program_loader; expected memory images are
// computed from the byte stream with plain arithmetic.
module tb_uart_program_loader;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        i_tx_ready;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        o_imem_we;
  logic [13:0] o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_cpu_run;
  logic        o_busy;
  logic        o_load_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  prog[$];
  logic [31:0] wq_data[$];
  logic [13:0] wq_addr[$];
  int hs, txbad, txcyc;

  uart_program_loader dut (
    .i_sys_clock (clk),
    .i_reset     (i_reset),
    .i_rx_valid  (i_rx_valid),
    .i_rx_data   (i_rx_data),
    .i_tx_ready  (i_tx_ready),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .o_imem_we   (o_imem_we),
    .o_imem_addr (o_imem_addr),
    .o_imem_wdata(o_imem_wdata),
    .o_cpu_run   (o_cpu_run),
    .o_busy      (o_busy),
    .o_load_err  (o_load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_imem_we === 1'b1) begin
      wq_data.push_back(o_imem_wdata);
      wq_addr.push_back(o_imem_addr);
    end
    if (o_tx_valid === 1'b1) begin
      txcyc++;
      if (o_tx_data !== 8'hAA) txbad++;
      if (i_tx_ready === 1'b1) hs++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) begin
      send_byte(n[8*i +: 8]);
      idle($urandom_range(0, 2));
    end
    idle(2);
  endtask

  task automatic send_prog(input int cnt, input bit bb);
    for (int i = 0; i < cnt; i++) begin
      send_byte(prog[i]);
      if (!bb) idle($urandom_range(0, 2));
    end
  endtask

  task automatic clear_mon();
    wq_data.delete();
    wq_addr.delete();
    hs = 0; txbad = 0; txcyc = 0;
  endtask

  task automatic do_reset(input string tag);
    i_reset = 1'b0; i_rx_valid = 1'b0; i_tx_ready = 1'b0; i_rx_data = 8'h00;
    @(negedge clk);
    chk({tag, "_outputs_in_reset"},
        {o_tx_valid, o_tx_data, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_run, o_busy, o_load_err}, 64'd0);
    @(posedge clk); #1;
    i_reset = 1'b1;
    idle(2);
  endtask

  task automatic fill_random(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
  endtask

  task automatic run_load(input int n, input bit bb, input int hold, input string name);
    logic [31:0] w;
    int nw, bad;
    bit found;
    clear_mon();
    send_len(32'(n));
    if (n > 0) begin
      @(negedge clk);
      chk({name, "_busy_loading"}, o_busy, 1'b1);
      @(posedge clk); #1;
    end
    send_prog(n, bb);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      found = (o_tx_valid === 1'b1);
    end
    chk({name, "_ack_seen"}, found, 1'b1);
    @(posedge clk); #1;
    bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (o_tx_valid !== 1'b1 || o_cpu_run !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk({name, "_tx_hold_stable"}, bad, 0);
    i_tx_ready = 1'b1;
    @(negedge clk);
    chk({name, "_run_before_hs"}, o_cpu_run, 1'b0);
    @(posedge clk); #1;
    i_tx_ready = 1'b0;
    @(negedge clk);
    chk({name, "_cpu_run_after_hs"}, o_cpu_run, 1'b1);
    chk({name, "_tx_valid_dropped"}, o_tx_valid, 1'b0);
    chk({name, "_busy_in_run"}, o_busy, 1'b0);
    @(posedge clk); #1;
    repeat (8) send_byte(8'($urandom));
    idle(3);
    @(negedge clk);
    chk({name, "_run_stays"}, {o_cpu_run, o_load_err}, 2'b10);
    @(posedge clk); #1;
    nw = (n + 3) / 4;
    chk({name, "_write_count"}, wq_data.size(), nw);
    bad = 0;
    for (int i = 0; i < nw; i++) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4*i + j < n) w = w | (32'(prog[4*i + j]) << (8*j));
      if (i >= wq_data.size()) bad++;
      else if (wq_data[i] !== w || wq_addr[i] !== 14'(i)) bad++;
    end
    chk({name, "_word_errors"}, bad, 0);
    chk({name, "_handshakes"}, hs, 1);
    chk({name, "_tx_data"}, txbad, 0);
    $display("load %s: bytes=%0d writes=%0d/%0d handshakes=%0d cpu_run=%0b",
             name, n, wq_data.size(), nw, hs, o_cpu_run);
  endtask

  initial begin
    logic [31:0] w0, w1, w41;
    i_reset = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_tx_ready = 1'b0;
    clear_mon();
    idle(1);
    do_reset("init");

    // Test 1: 168-byte program with known first and last words.
    fill_random(168);
    prog[0] = 8'h15; prog[1] = 8'h00; prog[2] = 8'h40; prog[3] = 8'h00;
    prog[164] = 8'h0E; prog[165] = 8'hC8; prog[166] = 8'hFF; prog[167] = 8'h37;
    run_load(168, 1'b0, 3, "t1");
    w0  = (wq_data.size() > 0)  ? wq_data[0]  : 32'hxxxxxxxx;
    w41 = (wq_data.size() > 41) ? wq_data[41] : 32'hxxxxxxxx;
    chk("t1_word0", w0, 32'h00400015);
    chk("t1_word41", w41, 32'h37FFC80E);

    // Test 2: six bytes, partial second word.
    do_reset("t2");
    prog.delete();
    for (int i = 1; i <= 6; i++) prog.push_back(8'(i));
    run_load(6, 1'b0, 0, "t2");
    w0 = (wq_data.size() > 0) ? wq_data[0] : 32'hxxxxxxxx;
    w1 = (wq_data.size() > 1) ? wq_data[1] : 32'hxxxxxxxx;
    chk("t2_word0", w0, 32'h04030201);
    chk("t2_word1", w1, 32'h00000605);

    // Test 3: zero-length load.
    do_reset("t3");
    prog.delete();
    run_load(0, 1'b0, 1, "t3");

    // Test 4: oversize count.
    do_reset("t4");
    clear_mon();
    send_len(32'h00010001);
    repeat (1000) begin
      i_rx_valid = 1'($urandom_range(0, 1));
      i_rx_data  = 8'($urandom);
      i_tx_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    i_rx_valid = 1'b0; i_tx_ready = 1'b0;
    @(negedge clk);
    chk("t4_load_err", o_load_err, 1'b1);
    chk("t4_cpu_run", o_cpu_run, 1'b0);
    chk("t4_busy", o_busy, 1'b0);
    chk("t4_writes", wq_data.size(), 0);
    chk("t4_tx_cycles", txcyc, 0);
    $display("load t4: count=0x00010001 load_err=%0b writes=%0d tx_cycles=%0d",
             o_load_err, wq_data.size(), txcyc);
    @(posedge clk); #1;

    // Test 5: reset after 50 of 168 bytes, then a full reload.
    do_reset("t5a");
    fill_random(168);
    send_len(32'd168);
    send_prog(50, 1'b0);
    do_reset("t5_mid");
    $display("load t5_abort: 50 of 168 bytes sent, writes before reset=%0d", wq_data.size());
    fill_random(168);
    run_load(168, 1'b0, 2, "t5");

    // Test 6: back-to-back data bytes, long ACK stall, random lengths.
    do_reset("t6");
    fill_random(37);
    run_load(37, 1'b1, 20, "t6");
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, 60);
      do_reset("t7");
      fill_random(n);
      run_load(n, 1'($urandom_range(0, 1)), $urandom_range(0, 5), "t7_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
